// File: rtl/step_sequencer_if.sv
// Control/status bundle between the processor control FSM (master) and
// the one-hot step sequencer (slave).
interface step_sequencer_if #(
  parameter int STEPS = 5,
  parameter int DIV_W = 8
);
  localparam int IDX_W = $clog2(STEPS);

  // Requests from the control FSM
  logic             start;
  logic             stop;
  logic             stall;
  logic             jump;
  logic [IDX_W-1:0] jump_idx;
  logic [IDX_W-1:0] last_idx;
  logic [DIV_W-1:0] div;
  logic             loop;

  // Step outputs and status strobes
  logic [STEPS-1:0] step;
  logic [IDX_W-1:0] step_idx;
  logic             busy;
  logic             step_adv;
  logic             wrap;
  logic             done;

  modport master (
    output start, stop, stall, jump, jump_idx, last_idx, div, loop,
    input  step, step_idx, busy, step_adv, wrap, done
  );

  modport slave (
    input  start, stop, stall, jump, jump_idx, last_idx, div, loop,
    output step, step_idx, busy, step_adv, wrap, done
  );
endinterface

// File: rtl/step_sequencer.sv
// One-hot step sequencer for the processor's multi-cycle control phases.
// Each step dwells div+1 cycles; supports one-shot/loop, stall, stop and
// jump-to-step, with step_adv / wrap / done strobes for the control FSM.
module step_sequencer #(
  parameter int STEPS = 5,
  parameter int DIV_W = 8,
  parameter int IDX_W = $clog2(STEPS)
) (
  input  logic          clock,
  input  logic          reset,
  step_sequencer_if.slave ctl
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DIV_W-1:0] pcnt, pcnt_n;
  logic [IDX_W-1:0] last_r, last_n;
  logic [DIV_W-1:0] div_r, div_n;
  logic             adv_r, adv_n;
  logic             wrap_r, wrap_n;
  logic             done_r, done_n;

  // State and datapath registers; async active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      pcnt   <= '0;
      last_r <= '0;
      div_r  <= '0;
      adv_r  <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      pcnt   <= pcnt_n;
      last_r <= last_n;
      div_r  <= div_n;
      adv_r  <= adv_n;
      wrap_r <= wrap_n;
      done_r <= done_n;
    end
  end

  // Next state: stop > jump > stall > tick; strobes registered one cycle ahead
  always_comb begin
    state_n = state;
    idx_n   = idx;
    pcnt_n  = pcnt;
    last_n  = last_r;
    div_n   = div_r;
    adv_n   = 1'b0;
    wrap_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          state_n = RUN;
          idx_n   = '0;
          pcnt_n  = '0;
          last_n  = (ctl.last_idx > MAX_IDX) ? MAX_IDX : ctl.last_idx;
          div_n   = ctl.div;
          adv_n   = 1'b1;
        end
      end
      RUN: begin
        if (ctl.stop) begin
          state_n = IDLE;
          idx_n   = '0;
          pcnt_n  = '0;
        end else if (ctl.jump) begin
          idx_n  = (ctl.jump_idx > last_r) ? last_r : ctl.jump_idx;
          pcnt_n = '0;
          adv_n  = 1'b1;
        end else if (!ctl.stall) begin
          if (pcnt == div_r) begin
            pcnt_n = '0;
            if (idx < last_r) begin
              idx_n = idx + IDX_W'(1);
              adv_n = 1'b1;
            end else if (ctl.loop) begin
              idx_n  = '0;
              adv_n  = 1'b1;
              wrap_n = 1'b1;
            end else begin
              state_n = IDLE;
              idx_n   = '0;
              done_n  = 1'b1;
            end
          end else begin
            pcnt_n = pcnt + DIV_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs: one-hot decode of the index, gated to zero outside RUN
  always_comb begin
    ctl.step     = '0;
    ctl.step_idx = idx;
    ctl.busy     = (state == RUN);
    ctl.step_adv = adv_r;
    ctl.wrap     = wrap_r;
    ctl.done     = done_r;
    if (state == RUN) ctl.step = STEPS'(1) << idx;
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Randomised + directed bench for step_sequencer with a behavioural model
// (elapsed-cycle counter against dwell length) compared every cycle.
module tb_step_sequencer;

  localparam int STEPS = 5;
  localparam int DIV_W = 8;
  localparam int IDX_W = $clog2(STEPS);

  logic clk;
  logic rst_n;

  step_sequencer_if #(.STEPS(STEPS), .DIV_W(DIV_W)) bus ();

  step_sequencer #(.STEPS(STEPS), .DIV_W(DIV_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: run flag, step index, cycles elapsed in step, dwell
  bit m_run;
  int m_idx, m_el, m_last, m_dw;
  bit m_adv, m_wrap, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_el = 0; m_last = 0; m_dw = 1;
    m_adv = 0; m_wrap = 0; m_done = 0;
  endtask

  // Apply the rules for the coming edge using the currently driven inputs
  task automatic model_next();
    m_adv = 0; m_wrap = 0; m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (bus.start) begin
        m_run  = 1;
        m_idx  = 0;
        m_el   = 0;
        m_last = (int'(bus.last_idx) > STEPS - 1) ? STEPS - 1 : int'(bus.last_idx);
        m_dw   = int'(bus.div) + 1;
        m_adv  = 1;
      end
    end else if (bus.stop) begin
      m_run = 0; m_idx = 0; m_el = 0;
    end else if (bus.jump) begin
      m_idx = (int'(bus.jump_idx) > m_last) ? m_last : int'(bus.jump_idx);
      m_el  = 0;
      m_adv = 1;
    end else if (!bus.stall) begin
      if (m_el + 1 == m_dw) begin
        m_el = 0;
        if (m_idx < m_last) begin
          m_idx++; m_adv = 1;
        end else if (bus.loop) begin
          m_idx = 0; m_adv = 1; m_wrap = 1;
        end else begin
          m_run = 0; m_idx = 0; m_done = 1;
        end
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic compare_all();
    chk("step",     32'(bus.step),     m_run ? (32'd1 << m_idx) : 32'd0);
    chk("step_idx", 32'(bus.step_idx), m_run ? 32'(m_idx) : 32'd0);
    chk("busy",     32'(bus.busy),     32'(m_run));
    chk("step_adv", 32'(bus.step_adv), 32'(m_adv));
    chk("wrap",     32'(bus.wrap),     32'(m_wrap));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("pcnt",     32'(dut.pcnt),     32'(m_el));
  endtask

  // One clock: model the edge, then sample 1 time unit after it
  task automatic cycle();
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.stall = 0; bus.jump = 0;
    bus.jump_idx = '0; bus.last_idx = '0; bus.div = '0; bus.loop = 0;
  endtask

  task automatic begin_seq(input int last, input int dv, input bit lp);
    bus.last_idx = IDX_W'(last);
    bus.div      = DIV_W'(dv);
    bus.loop     = lp;
    bus.start    = 1;
    cycle();
    bus.start    = 0;
  endtask

  int bc;
  int stalls;
  logic [DIV_W-1:0] held;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #2;
    chk("reset_step", 32'(bus.step), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_pcnt", 32'(dut.pcnt), 0);
    chk("reset_last_r", 32'(dut.last_r), 0);
    chk("reset_div_r", 32'(dut.div_r), 0);
    cycle();
    cycle();
    #2 rst_n = 1;
    cycle();

    // Basic 5-step one-shot, div=0
    begin_seq(4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("basic_step", 32'(bus.step), 32'd1 << i);
      chk("basic_adv", 32'(bus.step_adv), 1);
      chk("basic_busy", 32'(bus.busy), 1);
      cycle();
    end
    chk("basic_done", 32'(bus.done), 1);
    chk("basic_done_step", 32'(bus.step), 0);
    chk("basic_done_busy", 32'(bus.busy), 0);
    cycle();
    chk("basic_done_once", 32'(bus.done), 0);

    // Dwell 3, loop over steps 0..2
    begin_seq(2, 2, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) chk("loop_step1_at4", 32'(bus.step_idx), 1);
      if (c == 10) begin
        chk("loop_wrap_idx", 32'(bus.step_idx), 0);
        chk("loop_wrap", 32'(bus.wrap), 1);
        chk("loop_wrap_adv", 32'(bus.step_adv), 1);
      end
      chk("loop_no_done", 32'(bus.done), 0);
      cycle();
    end
    bus.stop = 1;
    cycle();
    bus.stop = 0;
    cycle();

    // Stall 4 cycles during step 1: busy 8+4
    begin_seq(3, 1, 0);
    bc = 0; stalls = 0; held = '0;
    for (int c = 0; c < 40 && bus.busy; c++) begin
      bc++;
      if (bus.step_idx == 1 && stalls < 4) begin
        if (stalls == 0) held = dut.pcnt;
        else chk("stall_pcnt_hold", 32'(dut.pcnt), 32'(held));
        bus.stall = 1;
        stalls++;
      end else begin
        bus.stall = 0;
      end
      cycle();
    end
    bus.stall = 0;
    chk("stall_busy_len", bc, 12);
    chk("stall_done", 32'(bus.done), 1);
    cycle();

    // Jump clamp, then jump+stop together
    begin_seq(2, 3, 1);
    cycle();
    bus.jump = 1; bus.jump_idx = 3'd4;
    cycle();
    bus.jump = 0;
    chk("jump_clamp", 32'(bus.step_idx), 2);
    chk("jump_adv", 32'(bus.step_adv), 1);
    cycle();
    bus.jump = 1; bus.stop = 1;
    cycle();
    bus.jump = 0; bus.stop = 0;
    chk("jstop_busy", 32'(bus.busy), 0);
    chk("jstop_step", 32'(bus.step), 0);
    chk("jstop_done", 32'(bus.done), 0);
    cycle();
    chk("jstop_done_late", 32'(bus.done), 0);

    // Oversized last_idx clamps; start while busy is ignored
    begin_seq(7, 0, 0);
    bc = 0;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      bc++;
      bus.start = (c == 1);
      cycle();
    end
    bus.start = 0;
    chk("clamp_len", bc, 5);
    cycle();

    // Single step, all-ones prescaler: 256-cycle dwell
    begin_seq(0, 255, 0);
    bc = 0;
    for (int c = 0; c < 400 && bus.busy; c++) begin
      bc++;
      cycle();
    end
    chk("maxdiv_len", bc, 256);
    chk("maxdiv_done", 32'(bus.done), 1);
    cycle();

    // Async reset in the middle of step 3
    begin_seq(4, 1, 1);
    for (int c = 0; c < 20 && bus.step_idx != 3; c++) cycle();
    chk("areset_reach3", 32'(bus.step_idx), 3);
    #2 rst_n = 0;
    #1;
    chk("areset_step", 32'(bus.step), 0);
    chk("areset_idx", 32'(bus.step_idx), 0);
    chk("areset_busy", 32'(bus.busy), 0);
    chk("areset_adv", 32'(bus.step_adv), 0);
    chk("areset_pcnt", 32'(dut.pcnt), 0);
    model_reset();
    cycle();
    #3 rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("post_rst_idle", 32'(bus.busy | bus.step_adv | bus.wrap | bus.done), 0);
    end

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.stop     = ($urandom_range(0, 63) == 0);
      bus.jump     = ($urandom_range(0, 23) == 0);
      bus.stall    = ($urandom_range(0, 4) == 0);
      bus.jump_idx = IDX_W'($urandom_range(0, 7));
      bus.last_idx = IDX_W'($urandom_range(0, 7));
      bus.div      = ($urandom_range(0, 49) == 0) ? 8'hFF : DIV_W'($urandom_range(0, 3));
      bus.loop     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
